// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch stage:
//   - MIPS R-format field bit positions inside a 32-bit instruction word
//   - INSTR_BYTES : bytes per instruction word
//   - fetch_state_t : fetch FSM state encoding
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int INSTR_BYTES = 4;

    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;
    localparam int RS_HI     = 25;
    localparam int RS_LO     = 21;
    localparam int RT_HI     = 20;
    localparam int RT_LO     = 16;
    localparam int RD_HI     = 15;
    localparam int RD_LO     = 11;
    localparam int SHAMT_HI  = 10;
    localparam int SHAMT_LO  = 6;
    localparam int FUNCT_HI  = 5;
    localparam int FUNCT_LO  = 0;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_mem.sv
// -----------------------------------------------------------------------------
// fetch_mem
// Byte-addressed instruction memory.
//   clk         : write clock
//   wr_en       : write one byte (ignored when wr_addr is out of range)
//   wr_addr     : byte address of the write
//   wr_data     : byte to write
//   rd_addr     : byte address of the word read (combinational)
//   rd_data     : big-endian word mem[rd_addr] .. mem[rd_addr+3], 0 if out of range
//   rd_in_range : rd_addr+3 lies inside the memory
// Contents are not reset.
// -----------------------------------------------------------------------------
module fetch_mem #(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 1024
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data,
    output logic              rd_in_range
);
    import fetch_pkg::*;

    localparam int IDX_W = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

    logic [7:0]        mem [MEM_BYTES];
    logic [ADDR_W:0]   last_byte;
    logic              wr_in_range;
    logic [IDX_W-1:0]  rd_base;

    // One extra bit so that an address near the top of the space cannot
    // wrap around and look in range.
    assign last_byte   = {1'b0, rd_addr} + (ADDR_W+1)'(INSTR_BYTES - 1);
    assign rd_in_range = last_byte < (ADDR_W+1)'(MEM_BYTES);
    assign wr_in_range = {1'b0, wr_addr} < (ADDR_W+1)'(MEM_BYTES);
    assign rd_base     = rd_addr[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (wr_en && wr_in_range) begin
            mem[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_in_range) begin
            for (int k = 0; k < INSTR_BYTES; k++) begin
                rd_data[(31 - 8*k) -: 8] = mem[rd_base + IDX_W'(k)];
            end
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// MIPS instruction fetch stage: PC, instruction memory, output register with
// valid/ready handshake, redirect/flush, program-load port and fault state.
//   CLK, RESET_N          : clock, async active-low reset
//   ENABLE                : permit new fetches
//   REDIRECT_VALID/_PC    : load PC with target and flush the output word
//   LOAD_EN/_ADDR/_DATA   : byte write into instruction memory
//   INSTR_READY           : downstream accepts the output word
//   INSTR_VALID           : output word and fields valid
//   INSTRUCTION, INSTR_PC : registered word and its address
//   OPCODE..FUNCT         : pre-split fields of INSTRUCTION
//   FAULT                 : stopped on misaligned / out-of-range PC
//   FETCH_COUNT           : completed handshakes (wraps)
//
// state | meaning
// RUN   | fetching, one word per cycle when downstream keeps up
// FAULT | stopped on a bad PC, no output; left only by redirect or reset
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int              ADDR_W    = 32,
    parameter int              MEM_BYTES = 1024,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              CNT_W     = 16
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              ENABLE,
    input  logic              REDIRECT_VALID,
    input  logic [ADDR_W-1:0] REDIRECT_PC,
    input  logic              LOAD_EN,
    input  logic [ADDR_W-1:0] LOAD_ADDR,
    input  logic [7:0]        LOAD_DATA,
    input  logic              INSTR_READY,
    output logic              INSTR_VALID,
    output logic [31:0]       INSTRUCTION,
    output logic [ADDR_W-1:0] INSTR_PC,
    output logic [5:0]        OPCODE,
    output logic [4:0]        RS,
    output logic [4:0]        RT,
    output logic [4:0]        RD,
    output logic [4:0]        SHAMT,
    output logic [5:0]        FUNCT,
    output logic              FAULT,
    output logic [CNT_W-1:0]  FETCH_COUNT
);
    import fetch_pkg::*;

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic              valid_q;
    logic              fault_q;
    logic [31:0]       instr_q;
    logic [ADDR_W-1:0] instr_pc_q;
    logic [CNT_W-1:0]  count_q;

    logic [31:0]       mem_word;
    logic              mem_in_range;
    logic              pc_bad;
    logic              fetch_slot;
    logic              handshake;

    fetch_mem #(
        .ADDR_W    (ADDR_W),
        .MEM_BYTES (MEM_BYTES)
    ) u_mem (
        .clk         (CLK),
        .wr_en       (LOAD_EN),
        .wr_addr     (LOAD_ADDR),
        .wr_data     (LOAD_DATA),
        .rd_addr     (pc),
        .rd_data     (mem_word),
        .rd_in_range (mem_in_range)
    );

    assign pc_bad     = (pc[1:0] != 2'b00) || !mem_in_range;
    // A slot opens when the output register is free or is being emptied now.
    assign fetch_slot = ENABLE && (state == fetch_pkg::RUN) && (!valid_q || INSTR_READY);
    assign handshake  = valid_q && INSTR_READY;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= fetch_pkg::RUN;
            pc         <= RESET_PC;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            count_q    <= '0;
        end else if (REDIRECT_VALID) begin
            // Flushed word is dropped without counting as a handshake.
            state   <= fetch_pkg::RUN;
            fault_q <= 1'b0;
            pc      <= REDIRECT_PC;
            valid_q <= 1'b0;
        end else begin
            if (handshake) begin
                count_q <= count_q + 1'b1;
            end
            case (state)
                fetch_pkg::RUN: begin
                    if (fetch_slot && pc_bad) begin
                        // Any valid word was handed off at this edge.
                        state   <= fetch_pkg::FAULT;
                        fault_q <= 1'b1;
                        valid_q <= 1'b0;
                    end else if (fetch_slot) begin
                        instr_q    <= mem_word;
                        instr_pc_q <= pc;
                        valid_q    <= 1'b1;
                        pc         <= pc + ADDR_W'(INSTR_BYTES);
                    end else if (handshake) begin
                        valid_q <= 1'b0;
                    end
                end
                fetch_pkg::FAULT: begin
                    valid_q <= 1'b0;
                    fault_q <= 1'b1;
                end
                default: begin
                    state   <= fetch_pkg::RUN;
                    valid_q <= 1'b0;
                    fault_q <= 1'b0;
                end
            endcase
        end
    end

    assign INSTR_VALID = valid_q;
    assign INSTRUCTION = instr_q;
    assign INSTR_PC    = instr_pc_q;
    assign OPCODE      = instr_q[OPCODE_HI:OPCODE_LO];
    assign RS          = instr_q[RS_HI:RS_LO];
    assign RT          = instr_q[RT_HI:RT_LO];
    assign RD          = instr_q[RD_HI:RD_LO];
    assign SHAMT       = instr_q[SHAMT_HI:SHAMT_LO];
    assign FUNCT       = instr_q[FUNCT_HI:FUNCT_LO];
    assign FAULT       = fault_q;
    assign FETCH_COUNT = count_q;

endmodule
